rfphoenix_branch_resolve: RTL and testbench

Branch resolution stage directly downstream of the branch evaluator. It accepts one evaluated branch per handshake and compares the actual outcome with the fetch-time prediction. On a mispredict it issues a held redirect/flush to fetch. It also trains a 2-bit saturating-counter branch history table (BHT) that fetch reads for the next prediction, and keeps branch and mispredict statistics.

---
 rtl/rfphoenix_branch_resolve_if.sv | 46 ++++
 rtl/rfphoenix_branch_resolve.sv | 161 ++++++++++++++++
 tb/tb_rfphoenix_branch_resolve.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rfphoenix_branch_resolve_if.sv
// ============================================================================
// Module   : rfphoenix_branch_resolve_if
// Brief    : Branch-in, redirect-out, BHT lookup and statistics bundle for
//            the branch resolution stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rfphoenix_branch_resolve_if #(
    parameter int AWID = 32
);
    logic            br_valid;
    logic            br_ready;
    logic            br_taken;
    logic [AWID-1:0] br_pc;
    logic [AWID-1:0] br_target;
    logic            br_pred_taken;
    logic [AWID-1:0] br_pred_target;

    logic            redirect_valid;
    logic [AWID-1:0] redirect_pc;
    logic            redirect_ack;
    logic            flush;

    logic [AWID-1:0] fetch_pc;
    logic            fetch_pred_taken;

    logic [31:0]     branch_cnt;
    logic [31:0]     mispredict_cnt;

    modport master (
        output br_valid, br_taken, br_pc, br_target, br_pred_taken, br_pred_target,
        output redirect_ack, fetch_pc,
        input  br_ready, redirect_valid, redirect_pc, flush, fetch_pred_taken,
        input  branch_cnt, mispredict_cnt
    );

    modport slave (
        input  br_valid, br_taken, br_pc, br_target, br_pred_taken, br_pred_target,
        input  redirect_ack, fetch_pc,
        output br_ready, redirect_valid, redirect_pc, flush, fetch_pred_taken,
        output branch_cnt, mispredict_cnt
    );
endinterface

`default_nettype wire

// File: rtl/rfphoenix_branch_resolve.sv
// ============================================================================
// Module   : rfphoenix_branch_resolve
// Brief    : Compares evaluated branches with their predictions, issues a held
//            redirect/flush on mispredict and trains a 2-bit counter BHT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rfphoenix_branch_resolve #(
    parameter int AWID         = 32,
    parameter int INSN_BYTES   = 5,
    parameter int BHT_BITS     = 9,
    parameter int IDX_LSB      = 0,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    rfphoenix_branch_resolve_if.slave bus
);

    localparam int BHT_ENTRIES = 1 << BHT_BITS;
    localparam int DW          = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = (FLUSH_CYCLES > 0) ? DW'(FLUSH_CYCLES - 1) : '0;
    localparam logic [1:0]    BHT_INIT   = 2'b01;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_REDIR = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BHT_BITS-1:0] sweep_q, sweep_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic [AWID-1:0]     redirect_pc_q, redirect_pc_d;
    logic [31:0]         branch_cnt_q, branch_cnt_d;
    logic [31:0]         mispredict_cnt_q, mispredict_cnt_d;
    logic                fetch_pred_q, fetch_pred_d;

    logic [1:0]          bht_q [BHT_ENTRIES];

    logic [BHT_BITS-1:0] upd_idx;
    logic [BHT_BITS-1:0] look_idx;
    logic [1:0]          upd_old;
    logic [1:0]          upd_new;
    logic                mispredict;
    logic [AWID-1:0]     fallthrough_pc;

    logic                bht_we;
    logic [BHT_BITS-1:0] bht_waddr;
    logic [1:0]          bht_wdata;

    logic                unused_ok;

    assign upd_idx        = bus.br_pc[IDX_LSB +: BHT_BITS];
    assign look_idx       = bus.fetch_pc[IDX_LSB +: BHT_BITS];
    assign fallthrough_pc = bus.br_pc + AWID'(INSN_BYTES);
    assign unused_ok      = ^bus.fetch_pc;

    assign mispredict = (bus.br_taken != bus.br_pred_taken) ||
                        (bus.br_taken && (bus.br_target != bus.br_pred_target));

    always_comb begin
        upd_old = bht_q[upd_idx];
        upd_new = upd_old;
        if (bus.br_taken) begin
            if (upd_old != 2'b11) upd_new = upd_old + 2'b01;
        end else begin
            if (upd_old != 2'b00) upd_new = upd_old - 2'b01;
        end
    end

    always_comb begin
        state_d          = state_q;
        sweep_d          = sweep_q;
        drain_d          = drain_q;
        redirect_pc_d    = redirect_pc_q;
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        bht_we           = 1'b0;
        bht_waddr        = sweep_q;
        bht_wdata        = BHT_INIT;

        case (state_q)
            ST_INIT: begin
                bht_we    = 1'b1;
                bht_waddr = sweep_q;
                bht_wdata = BHT_INIT;
                sweep_d   = sweep_q + BHT_BITS'(1);
                if (sweep_q == '1) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.br_valid) begin
                    if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_d = branch_cnt_q + 32'd1;
                    bht_we    = 1'b1;
                    bht_waddr = upd_idx;
                    bht_wdata = upd_new;
                    if (mispredict) begin
                        if (mispredict_cnt_q != 32'hFFFF_FFFF)
                            mispredict_cnt_d = mispredict_cnt_q + 32'd1;
                        redirect_pc_d = bus.br_taken ? bus.br_target : fallthrough_pc;
                        state_d       = ST_REDIR;
                    end
                end
            end
            ST_REDIR: begin
                if (bus.redirect_ack) begin
                    drain_d = '0;
                    state_d = (FLUSH_CYCLES > 0) ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = ST_IDLE;
                else                       drain_d = drain_q + DW'(1);
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Lookup reads the array before this edge's update lands (read-before-write).
    always_comb begin
        fetch_pred_d = 1'b0;
        if (state_q != ST_INIT) fetch_pred_d = bht_q[look_idx][1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_INIT;
            sweep_q          <= '0;
            drain_q          <= '0;
            redirect_pc_q    <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
            fetch_pred_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            sweep_q          <= sweep_d;
            drain_q          <= drain_d;
            redirect_pc_q    <= redirect_pc_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
            fetch_pred_q     <= fetch_pred_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && bht_we) bht_q[bht_waddr] <= bht_wdata;
    end

    assign bus.br_ready         = (state_q == ST_IDLE);
    assign bus.redirect_valid   = (state_q == ST_REDIR);
    assign bus.flush            = (state_q == ST_REDIR) || (state_q == ST_DRAIN);
    assign bus.redirect_pc      = redirect_pc_q;
    assign bus.fetch_pred_taken = fetch_pred_q;
    assign bus.branch_cnt       = branch_cnt_q;
    assign bus.mispredict_cnt   = mispredict_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rfphoenix_branch_resolve.sv
// ============================================================================
// Module   : tb_rfphoenix_branch_resolve
// Brief    : Directed plus randomized bench with a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rfphoenix_branch_resolve;

    localparam int AWID         = 32;
    localparam int INSN_BYTES   = 5;
    localparam int BHT_BITS     = 4;
    localparam int IDX_LSB      = 0;
    localparam int FLUSH_CYCLES = 2;
    localparam int NENT         = 1 << BHT_BITS;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rfphoenix_branch_resolve_if #(.AWID(AWID)) bus ();

    rfphoenix_branch_resolve #(
        .AWID(AWID), .INSN_BYTES(INSN_BYTES), .BHT_BITS(BHT_BITS),
        .IDX_LSB(IDX_LSB), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> IDX_LSB) % NENT);
    endfunction

    // Reference model: counters of remaining init/drain cycles and a plain int BHT.
    int          init_left  = NENT;
    bit          m_redir    = 1'b0;
    int          drain_left = 0;
    logic [31:0] m_rpc = '0, m_bc = '0, m_mc = '0;
    logic        m_fpt = 1'b0;
    int          bht_m [NENT];
    bit          started = 1'b0;

    always @(posedge clk) begin : model
        bit mp;
        int i;
        if (rst) begin
            init_left = NENT; m_redir = 1'b0; drain_left = 0;
            m_rpc = '0; m_fpt = 1'b0; m_bc = '0; m_mc = '0;
        end else if (init_left > 0) begin
            bht_m[NENT - init_left] = 1;
            init_left--;
        end else begin
            m_fpt = (bht_m[idx(bus.fetch_pc)] >= 2);
            if (m_redir) begin
                if (bus.redirect_ack) begin
                    m_redir    = 1'b0;
                    drain_left = FLUSH_CYCLES;
                end
            end else if (drain_left > 0) begin
                drain_left--;
            end else if (bus.br_valid) begin
                i = idx(bus.br_pc);
                if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
                if (bus.br_taken) bht_m[i] = (bht_m[i] < 3) ? bht_m[i] + 1 : 3;
                else              bht_m[i] = (bht_m[i] > 0) ? bht_m[i] - 1 : 0;
                mp = (bus.br_taken != bus.br_pred_taken) ||
                     (bus.br_taken && (bus.br_target != bus.br_pred_target));
                if (mp) begin
                    if (m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
                    m_rpc   = bus.br_taken ? bus.br_target : 32'(bus.br_pc + INSN_BYTES);
                    m_redir = 1'b1;
                end
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin : compare
        if (started) begin
            check("br_ready",         {31'b0, bus.br_ready},       {31'b0, (init_left == 0) && !m_redir && (drain_left == 0)});
            check("redirect_valid",   {31'b0, bus.redirect_valid}, {31'b0, m_redir});
            check("flush",            {31'b0, bus.flush},          {31'b0, m_redir || (drain_left > 0)});
            check("redirect_pc",      bus.redirect_pc,             m_rpc);
            check("fetch_pred_taken", {31'b0, bus.fetch_pred_taken}, {31'b0, m_fpt});
            check("branch_cnt",       bus.branch_cnt,              m_bc);
            check("mispredict_cnt",   bus.mispredict_cnt,          m_mc);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.br_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (!bus.br_ready) begin
            n_err++;
            $display("FAIL wait_ready: br_ready=0 after %0d cycles, required 1", n);
        end
    endtask

    // Presents one branch at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
        wait_ready();
        bus.br_valid       = 1'b1;
        bus.br_pc          = pc;
        bus.br_taken       = tk;
        bus.br_target      = tgt;
        bus.br_pred_taken  = ptk;
        bus.br_pred_target = ptgt;
        @(negedge clk);
        bus.br_valid = 1'b0;
    endtask

    task automatic ack_now();
        bus.redirect_ack = 1'b1;
        @(negedge clk);
        bus.redirect_ack = 1'b0;
    endtask

    task automatic init_sweep(input string name);
        int cnt = 0;
        while (!bus.br_ready && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check(name, cnt, NENT);
    endtask

    initial begin
        bus.br_valid = 1'b0; bus.br_taken = 1'b0; bus.br_pc = '0; bus.br_target = '0;
        bus.br_pred_taken = 1'b0; bus.br_pred_target = '0;
        bus.redirect_ack = 1'b0; bus.fetch_pc = 32'h0000_0123;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        init_sweep("init_len");
        @(negedge clk);
        check("lookup_after_init", {31'b0, bus.fetch_pred_taken}, 32'd0);

        send(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        check("nt_ok_bc", bus.branch_cnt, 32'd1);
        check("nt_ok_mc", bus.mispredict_cnt, 32'd0);
        check("nt_ok_rv", {31'b0, bus.redirect_valid}, 32'd0);
        check("nt_ok_ready", {31'b0, bus.br_ready}, 32'd1);

        send(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        check("tk_mp_rv", {31'b0, bus.redirect_valid}, 32'd1);
        check("tk_mp_rpc", bus.redirect_pc, 32'h200);
        check("tk_mp_flush", {31'b0, bus.flush}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("tk_mp_hold_rpc", bus.redirect_pc, 32'h200);
            check("tk_mp_hold_rv", {31'b0, bus.redirect_valid}, 32'd1);
        end
        ack_now();
        check("ack_rv_drop", {31'b0, bus.redirect_valid}, 32'd0);
        check("ack_flush1", {31'b0, bus.flush}, 32'd1);
        check("ack_ready1", {31'b0, bus.br_ready}, 32'd0);
        @(negedge clk);
        check("ack_flush2", {31'b0, bus.flush}, 32'd1);
        @(negedge clk);
        check("ack_flush3", {31'b0, bus.flush}, 32'd0);
        check("ack_ready3", {31'b0, bus.br_ready}, 32'd1);

        send(32'h1FC, 1'b0, 32'h0, 1'b1, 32'h0);
        check("nt_mp_rpc", bus.redirect_pc, 32'h201);
        ack_now();
        check("nt_mp_ack_first", {31'b0, bus.redirect_valid}, 32'd0);

        send(32'h40, 1'b1, 32'h300, 1'b1, 32'h304);
        check("tgt_mp_rpc", bus.redirect_pc, 32'h300);
        ack_now();
        send(32'hFFFF_FFFE, 1'b0, 32'h0, 1'b1, 32'h0);
        check("wrap_rpc", bus.redirect_pc, 32'h3);
        ack_now();
        wait_ready();
        check("bc_total", bus.branch_cnt, 32'd5);
        check("mc_total", bus.mispredict_cnt, 32'd4);

        bus.fetch_pc = 32'h5;
        repeat (5) send(32'h5, 1'b1, 32'h80, 1'b1, 32'h80);
        send(32'h5, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("sat_after_one_dec", {31'b0, bus.fetch_pred_taken}, 32'd1);
        send(32'h5, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("sat_after_two_dec", {31'b0, bus.fetch_pred_taken}, 32'd0);

        bus.fetch_pc = 32'h7;
        @(negedge clk);
        send(32'h7, 1'b1, 32'h90, 1'b1, 32'h90);
        check("bypass_old", {31'b0, bus.fetch_pred_taken}, 32'd0);
        @(negedge clk);
        check("bypass_new", {31'b0, bus.fetch_pred_taken}, 32'd1);

        send(32'h100, 1'b0, 32'h0, 1'b1, 32'h0);
        check("pre_rst_rv", {31'b0, bus.redirect_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_redir_rv", {31'b0, bus.redirect_valid}, 32'd0);
        check("rst_redir_flush", {31'b0, bus.flush}, 32'd0);
        check("rst_redir_bc", bus.branch_cnt, 32'd0);
        rst = 1'b0;
        init_sweep("init_len_again");

        for (int c = 0; c < 3000; c++) begin
            logic [31:0] tset [4];
            tset[0] = 32'h1000; tset[1] = 32'h1004; tset[2] = 32'h2000; tset[3] = 32'hFFFF_FFFC;
            bus.br_valid       = ($urandom_range(0, 3) != 0);
            bus.br_pc          = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom;
            bus.br_taken       = $urandom_range(0, 1) == 1;
            bus.br_pred_taken  = ($urandom_range(0, 3) == 0) ? !bus.br_taken : bus.br_taken;
            bus.br_target      = tset[$urandom_range(0, 3)];
            bus.br_pred_target = ($urandom_range(0, 3) == 0) ? tset[$urandom_range(0, 3)] : bus.br_target;
            bus.redirect_ack   = ($urandom_range(0, 2) == 0);
            bus.fetch_pc       = $urandom;
            rst                = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        bus.br_valid = 1'b0;
        bus.redirect_ack = 1'b1;
        repeat (NENT + 8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
